dmem: RTL and testbench



---
 rtl/dmem.sv | 135 +++++++++++++
 tb/tb_dmem.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dmem.sv
// Data memory with one-cycle registered reads plus an MMIO page (debug, cycle counter, console FIFO).
// Define DMEM_CONSOLE_EN to build the console transmit FIFO; otherwise TXSTAT/TXDATA read 0 and tx_* are tied low.
module dmem #(
    parameter int AW      = 10,
    parameter int TXDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] raddr,
    input  logic        re,
    output logic [15:0] rdata,
    input  logic [15:0] waddr,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic [15:0] dbg_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam logic [7:0] A_DBG    = 8'h00;
    localparam logic [7:0] A_CYCLE  = 8'h01;
    localparam logic [7:0] A_TXSTAT = 8'h02;
    localparam logic [7:0] A_TXDATA = 8'h03;

    logic        r_mmio, w_mmio;
    logic [15:0] cycle_q;
    logic [15:0] txstat;
    logic [15:0] mmio_rval;

    assign r_mmio = (raddr[15:8] == 8'hFF);
    assign w_mmio = (waddr[15:8] == 8'hFF);

    // NOTE: RAM contents carry no reset so the array maps onto block RAM; only the output register is reset.
    logic [15:0] ram [0:(1<<AW)-1];

    // NOTE: sequential state always uses non-blocking assignments; that is also what makes
    // a same-cycle read see the pre-write value.
    always_ff @(posedge clk) begin
        if (we && !w_mmio)
            ram[waddr[AW-1:0]] <= wdata;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mmio_rval = 16'h0000;
        case (raddr[7:0])
            A_DBG:    mmio_rval = dbg_out;
            A_CYCLE:  mmio_rval = cycle_q;
            A_TXSTAT: mmio_rval = txstat;
            default:  mmio_rval = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata <= 16'h0000;
        else if (re)
            rdata <= r_mmio ? mmio_rval : ram[raddr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst)
            dbg_out <= 16'h0000;
        else if (we && w_mmio && waddr[7:0] == A_DBG)
            dbg_out <= wdata;
    end

    // A CYCLE write replaces this cycle's increment; counting resumes from the written value.
    always_ff @(posedge clk) begin
        if (rst)
            cycle_q <= 16'h0000;
        else if (we && w_mmio && waddr[7:0] == A_CYCLE)
            cycle_q <= wdata;
        else
            cycle_q <= cycle_q + 16'd1;
    end

`ifdef DMEM_CONSOLE_EN
    localparam int PW = $clog2(TXDEPTH);

    logic [7:0]  tx_mem [0:TXDEPTH-1];
    logic [PW-1:0] wp, rp;
    logic [PW:0] count;
    logic        ovf;
    logic        full, empty, pop, push_req, push_ok;

    assign full     = (count == (PW+1)'(TXDEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && tx_ready;
    assign push_req = we && w_mmio && (waddr[7:0] == A_TXDATA);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);

    assign tx_valid = !empty;
    assign tx_data  = tx_mem[rp];
    assign txstat   = {13'b0, ovf, empty, full};

    always_ff @(posedge clk) begin
        if (push_ok)
            tx_mem[wp] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push_ok)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (we && w_mmio && waddr[7:0] == A_TXSTAT)
                ovf <= 1'b0;
            else if (push_req && full && !pop)
                ovf <= 1'b1;
        end
    end
`else
    logic unused_tx_ready;

    assign unused_tx_ready = tx_ready;
    assign tx_valid        = 1'b0;
    assign tx_data         = 8'h00;
    assign txstat          = 16'h0000;
`endif

endmodule

// File: tb/tb_dmem.sv
// Directed bench for dmem: RAM, read-before-write, DBG, CYCLE, console FIFO and mid-stream reset.
module tb_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] raddr, waddr, wdata;
    logic        re, we;
    logic [15:0] rdata, dbg_out;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;

    int errors = 0;
    int checks = 0;

    dmem #(.AW(10), .TXDEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .re       (re),
        .rdata    (rdata),
        .waddr    (waddr),
        .wdata    (wdata),
        .we       (we),
        .dbg_out  (dbg_out),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
        re = 1'b1; raddr = a;
        tick();
        re = 1'b0;
        check(tag, rdata, exp);
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; tx_ready = 1'b0;
        raddr = '0; waddr = '0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
        // Cycle 0: reset values.
        check("rst_rdata", rdata, 16'h0000);
        check("rst_dbg", dbg_out, 16'h0000);
        check("rst_tx_valid", 16'(tx_valid), 16'h0000);
        for (int i = 0; i < 7; i++) tick();
        rd(16'hFF01, 16'd7, "cycle_at_7");

        // RAM round trip, hold, alias.
        wr(16'h0005, 16'h1234);
        rd(16'h0005, 16'h1234, "ram_rt");
        tick(); tick();
        check("ram_hold", rdata, 16'h1234);
        rd(16'h0405, 16'h1234, "ram_alias");

        // Read-before-write on RAM.
        wr(16'h0010, 16'hAAAA);
        we = 1'b1; waddr = 16'h0010; wdata = 16'h5555;
        re = 1'b1; raddr = 16'h0010;
        tick();
        we = 1'b0; re = 1'b0;
        check("rbw_old", rdata, 16'hAAAA);
        rd(16'h0010, 16'h5555, "rbw_new");

        // DBG register, including read-before-write on MMIO.
        wr(16'hFF00, 16'hBEEF);
        check("dbg_out", dbg_out, 16'hBEEF);
        we = 1'b1; waddr = 16'hFF00; wdata = 16'h1111;
        re = 1'b1; raddr = 16'hFF00;
        tick();
        we = 1'b0; re = 1'b0;
        check("dbg_rbw", rdata, 16'hBEEF);
        check("dbg_out2", dbg_out, 16'h1111);

        // CYCLE write then wrap.
        wr(16'hFF01, 16'hFFFE);
        rd(16'hFF01, 16'hFFFE, "cycle_load");
        rd(16'hFF01, 16'hFFFF, "cycle_ffff");
        rd(16'hFF01, 16'h0000, "cycle_wrap");

        // Unmapped MMIO.
        wr(16'hFF10, 16'h7777);
        rd(16'hFF10, 16'h0000, "mmio_unmapped");
        rd(16'hFF03, 16'h0000, "txdata_read");

`ifdef DMEM_CONSOLE_EN
        // Fill past full with tx_ready low.
        for (int i = 0; i < 5; i++) wr(16'hFF03, 16'h0041 + 16'(i));
        rd(16'hFF02, 16'h0005, "txstat_full_ovf");
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("tx_valid_drain", 16'(tx_valid), 16'h0001);
            check("tx_data_drain", 16'(tx_data), 16'h0041 + 16'(i));
            tick();
        end
        check("tx_valid_empty", 16'(tx_valid), 16'h0000);
        tx_ready = 1'b0;
        wr(16'hFF02, 16'h0000);
        rd(16'hFF02, 16'h0002, "txstat_clear");

        // Push with a same-cycle TXSTAT read shows the pre-push state.
        we = 1'b1; waddr = 16'hFF03; wdata = 16'h0061;
        re = 1'b1; raddr = 16'hFF02;
        tick();
        we = 1'b0; re = 1'b0;
        check("txstat_prepush", rdata, 16'h0002);
        check("tx_valid_rise", 16'(tx_valid), 16'h0001);
        for (int i = 0; i < 3; i++) wr(16'hFF03, 16'h0062 + 16'(i));
        rd(16'hFF02, 16'h0001, "txstat_full");
        // Full: push 0x50 while popping 0x61.
        tx_ready = 1'b1;
        wr(16'hFF03, 16'h0050);
        tx_ready = 1'b0;
        rd(16'hFF02, 16'h0001, "txstat_no_ovf");
        tx_ready = 1'b1;
        check("tx_data_a", 16'(tx_data), 16'h0062); tick();
        check("tx_data_b", 16'(tx_data), 16'h0063); tick();
        check("tx_data_c", 16'(tx_data), 16'h0064); tick();
        check("tx_data_last", 16'(tx_data), 16'h0050); tick();
        check("tx_valid_end", 16'(tx_valid), 16'h0000);
        tx_ready = 1'b0;
`else
        wr(16'hFF03, 16'h0041);
        check("tx_valid_off", 16'(tx_valid), 16'h0000);
        check("tx_data_off", 16'(tx_data), 16'h0000);
        rd(16'hFF02, 16'h0000, "txstat_off");
`endif

        // Reset mid-stream.
        for (int i = 0; i < 3; i++) wr(16'hFF03, 16'h0071 + 16'(i));
        wr(16'hFF00, 16'hBEEF);
        rd(16'h0005, 16'h1234, "pre_rst_read");
        check("pre_rst_dbg", dbg_out, 16'hBEEF);
`ifdef DMEM_CONSOLE_EN
        check("pre_rst_valid", 16'(tx_valid), 16'h0001);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 16'(tx_valid), 16'h0000);
        check("mid_rst_dbg", dbg_out, 16'h0000);
        check("mid_rst_rdata", rdata, 16'h0000);
        rd(16'hFF01, 16'h0000, "mid_rst_cycle");
        rd(16'h0005, 16'h1234, "ram_survives_rst");
        rd(16'h0010, 16'h5555, "ram2_survives_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
